// File: rtl/fetch_icache_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_icache_ctrl
//   Sequencer between the fetch-1 PC stage and the instruction cache. Issues
//   one icache read per accepted PC, tracks the single outstanding access,
//   discards stale responses after a flush and holds a returned word while
//   decode is stalled. Also drives the fetch-stage stall seen by fetch-2.
//
// Optional feature macro: FETCH_CTRL_PERF_EN
//   defined   : perf_miss_cycles / perf_drop_cnt are saturating counters
//   undefined : both perf ports are tied to zero and no counter flops exist
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_pc    PC offered by fetch-1; accepted on req_valid & req_ready
//   req_ready           PC accept strobe back to fetch-1
//   is_flush            pipeline flush/redirect
//   is_stall            decode stall
//   ic_req/ic_addr      one-cycle icache read strobe and address
//   ic_ready/ic_data    one-cycle icache response pulse and instruction
//   resp_valid/inst/pc  instruction handed to fetch-2/decode
//   fetch_stall         fetch stage waiting on the icache
//   perf_miss_cycles    cycles with fetch_stall asserted
//   perf_drop_cnt       discarded icache responses
// -----------------------------------------------------------------------------
module fetch_icache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    input  logic              is_flush,
    input  logic              is_stall,
    output logic              ic_req,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_ready,
    input  logic [DATA_W-1:0] ic_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_inst,
    output logic [ADDR_W-1:0] resp_pc,
    output logic              fetch_stall,
    output logic [31:0]       perf_miss_cycles,
    output logic [15:0]       perf_drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_hold_inst;
    logic [ADDR_W-1:0] r_hold_pc;
    logic              w_accept;
    logic              w_capture;

    // Next-state and combinational outputs; acceptance is resolved per state
    // into req_ready and then qualified with req_valid in one place below.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_inst    = {DATA_W{1'b0}};
        resp_pc      = {ADDR_W{1'b0}};
        fetch_stall  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = ~is_flush;
            end
            ST_WAIT: begin
                if (!ic_ready) begin
                    fetch_stall = 1'b1;
                    if (is_flush) begin
                        w_next_state = ST_DROP;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end else if (is_flush) begin
                    // Response returns into a flush: discard it, no issue.
                    w_next_state = ST_IDLE;
                end else begin
                    resp_valid = 1'b1;
                    resp_inst  = ic_data;
                    resp_pc    = r_pc;
                    if (is_stall) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_HOLD;
                    end else begin
                        req_ready    = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (is_flush) begin
                    w_next_state = ST_IDLE;
                end else begin
                    resp_valid = 1'b1;
                    resp_inst  = r_hold_inst;
                    resp_pc    = r_hold_pc;
                    if (!is_stall) begin
                        req_ready    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            ST_DROP: begin
                fetch_stall = 1'b1;
                if (ic_ready) begin
                    req_ready    = ~is_flush;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DROP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // Any accepted PC issues immediately and overrides the IDLE target.
        if (w_accept) begin
            w_next_state = ST_WAIT;
        end else begin
            w_next_state = w_next_state;
        end
    end

    assign w_accept = req_valid & req_ready;
    assign ic_req   = w_accept;
    assign ic_addr  = req_pc;

    // State, outstanding PC and hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= {ADDR_W{1'b0}};
            r_hold_inst <= {DATA_W{1'b0}};
            r_hold_pc   <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_pc <= req_pc;
            end
            if (w_capture) begin
                r_hold_inst <= ic_data;
                r_hold_pc   <= r_pc;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_perf_miss;
    logic [15:0] r_perf_drop;
    logic        w_drop;

    // A flushed HOLD word is deliberately not a drop: it was already delivered.
    assign w_drop = ic_ready & (((r_state == ST_WAIT) & is_flush) | (r_state == ST_DROP));

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_miss <= 32'd0;
            r_perf_drop <= 16'd0;
        end else begin
            if (fetch_stall && (r_perf_miss != 32'hFFFF_FFFF)) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
            if (w_drop && (r_perf_drop != 16'hFFFF)) begin
                r_perf_drop <= r_perf_drop + 16'd1;
            end
        end
    end

    assign perf_miss_cycles = r_perf_miss;
    assign perf_drop_cnt    = r_perf_drop;
`else
    assign perf_miss_cycles = 32'd0;
    assign perf_drop_cnt    = 16'd0;
`endif

endmodule

// File: doc/fetch_icache_ctrl.md
# fetch_icache_ctrl

Sequencer between the fetch-1 PC stage and the instruction cache. It issues one icache read per accepted PC and tracks the single outstanding access. On a pipeline flush it discards the stale response. When decode stalls at response time, it holds the returned word. It also drives the fetch-stage stall that fetch-2 consumes.

## Interface
Parameters:
- `ADDR_W`, default 32: PC / icache address width.
- `DATA_W`, default 32: instruction word width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: fetch-1 presents a PC.
- `req_pc` in ADDR_W: PC to fetch.
- `req_ready` out 1: PC is accepted this cycle when `req_valid & req_ready`.
- `is_flush` in 1: pipeline flush/redirect; a redirect PC may arrive on `req_pc` the same or a later cycle.
- `is_stall` in 1: downstream (decode) stall.
- `ic_req` out 1: one-cycle icache read strobe.
- `ic_addr` out ADDR_W: address qualified by `ic_req`.
- `ic_ready` in 1: one-cycle response pulse; earliest one cycle after `ic_req`.
- `ic_data` in DATA_W: instruction, valid with `ic_ready`.
- `resp_valid` out 1: instruction presented to fetch-2/decode; a transfer occurs on `resp_valid & ~is_stall`.
- `resp_inst` out DATA_W: instruction word.
- `resp_pc` out ADDR_W: PC of `resp_inst`.
- `fetch_stall` out 1: fetch stage waiting on icache.
- `perf_miss_cycles` out 32: cycles with `fetch_stall`=1 (see Configuration).
- `perf_drop_cnt` out 16: discarded icache responses (see Configuration).

## Operation
FSM states: IDLE, WAIT, HOLD, DROP. Registers: `pc_r` (outstanding PC), `hold_inst`, `hold_pc`.

Issue rule: an accepted request sets `ic_req`=1 and `ic_addr`=`req_pc` combinationally in the same cycle. `pc_r` takes `req_pc` and the next state is WAIT. The conditions under which a request is accepted are listed per state below.

- **IDLE:** `req_ready` = `~is_flush`. Issues on `req_valid & ~is_flush`.
- **WAIT, `ic_ready`=0:**
  - `is_flush` → DROP.
  - Otherwise stay in WAIT.
- **WAIT, `ic_ready`=1, `is_flush`=1:** the response is discarded (counts as a drop); next state IDLE; no issue.
- **WAIT, `ic_ready`=1, `is_flush`=0:**
  - `resp_valid`=1, `resp_inst`=`ic_data`, `resp_pc`=`pc_r`, all combinational.
  - If `is_stall`: capture into the hold registers → HOLD.
  - Else: `req_ready`=1. A new request issues back-to-back and stays in WAIT; with no new request → IDLE.
- **HOLD:** `resp_valid`=1 from the hold registers.
  - `is_flush` drops the held word → IDLE; `resp_valid` is forced to 0 that cycle.
  - Else, when `~is_stall`: the transfer completes and `req_ready`=1 (issue allowed) → WAIT or IDLE.
- **DROP:** waits for the stale response; `resp_valid`=0.
  - On `ic_ready`: the response is discarded and `req_ready`=`~is_flush`. With `req_valid`, the redirect PC issues the same cycle → WAIT; otherwise → IDLE.
  - A further `is_flush` in DROP keeps the FSM in DROP.

Derived outputs:
- `fetch_stall` = `(WAIT & ~ic_ready) | DROP`.
- `ic_ready` in IDLE or HOLD is a protocol violation; it is ignored.
- At most one icache access is ever outstanding.

## Timing
- Reset (`rst`=1 at a rising edge): state IDLE.
  - `ic_req`, `resp_valid`, `fetch_stall` = 0; `req_ready` = 1 when `is_flush`=0.
  - Hold/PC registers and perf counters = 0.
- Reset mid-WAIT or mid-DROP abandons the access. The icache must be reset in the same cycle; no response is expected afterwards.
- Fetch latency is N+0 cycles: `resp_valid` is asserted in the same cycle as `ic_ready`, where `ic_ready` arrives N cycles after `ic_req`.
- Peak throughput is one instruction per cycle, with a 1-cycle icache and no stalls.
- All outputs except the perf counters and the hold data are combinational from state and inputs.

## Configuration
- `FETCH_CTRL_PERF_EN` defined:
  - `perf_miss_cycles` increments every cycle `fetch_stall`=1.
  - `perf_drop_cnt` increments for every discarded response: WAIT+`ic_ready`+`is_flush`, or DROP+`ic_ready`. A flushed HOLD word is not counted.
  - Both counters saturate at all-ones and clear on `rst`.
- Not defined: both ports are tied to constant 0 and no counter flops exist.

## Test plan
- **Single fetch:** `req_pc`=0x1C000000 accepted; `ic_ready` 3 cycles later with `ic_data`=0x02800C0C → `fetch_stall`=1 for 2 cycles; `resp_valid`=1 for exactly 1 cycle with `resp_pc`=0x1C000000 and `resp_inst`=0x02800C0C; then IDLE.
- **Back-to-back:** 1-cycle icache, PCs 0x1C000000/04/08 → `ic_req` on 3 consecutive cycles; `resp_valid` on 3 consecutive cycles with matching PCs.
- **Downstream stall at return:** `is_stall`=1 for 4 cycles spanning `ic_ready` → `resp_valid` held with constant PC/inst; `req_ready`=0 until `is_stall` falls; transfer completes on the first `~is_stall` cycle.
- **Flush while waiting:** `is_flush` 1 cycle after `ic_req`; redirect `req_pc`=0x1C000100 valid → no `resp_valid` for the old PC. Redirect `ic_req` with `ic_addr`=0x1C000100 coincides with the stale `ic_ready`; `perf_drop_cnt`=1 when PERF_EN is defined.
- **Flush coincident with `ic_ready`:** → `resp_valid`=0, no issue that cycle, next state IDLE.
- **Reset mid-WAIT:** `rst` 2 cycles after `ic_req` → next cycle IDLE, all outputs at reset values; `perf_miss_cycles`=0.
